// File: rtl/cache_direct_mapped_param.sv
`default_nettype none
// cache_direct_mapped_param: direct-mapped, write-through, no-write-allocate cache with
// ready/valid CPU and memory ports, coherence invalidate and saturating hit/miss counters.
module cache_direct_mapped_param #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORD_WIDTH      = 8,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int NUM_BLOCKS      = 128,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  cpu_req_valid,
  output logic                                  cpu_req_ready,
  input  logic                                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0]                 cpu_req_addr,
  input  logic [WORD_WIDTH-1:0]                 cpu_req_wdata,
  output logic                                  cpu_resp_valid,
  output logic [WORD_WIDTH-1:0]                 cpu_resp_data,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic                                  mem_req_write,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  output logic [WORD_WIDTH-1:0]                 mem_req_wdata,
  input  logic                                  mem_resp_valid,
  input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_resp_data,
  input  logic                                  inv_valid,
  input  logic [ADDR_WIDTH-1:0]                 inv_addr,
  output logic [COUNTER_WIDTH-1:0]              hit_count,
  output logic [COUNTER_WIDTH-1:0]              miss_count
);
  localparam int OFF = $clog2(WORDS_PER_BLOCK);
  localparam int IDX = $clog2(NUM_BLOCKS);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_RESPOND
  } state_t;

  state_t                   state_q, state_d;
  logic                     req_write_q;
  logic [ADDR_WIDTH-1:0]    req_addr_q;
  logic [WORD_WIDTH-1:0]    req_wdata_q;
  logic [NUM_BLOCKS-1:0]    valid_q;
  logic [TAG-1:0]           tag_mem  [NUM_BLOCKS];
  logic [WORD_WIDTH-1:0]    data_mem [NUM_BLOCKS][WORDS_PER_BLOCK];
  logic                     inv_pend_q;
  logic                     mem_write_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;
  logic [WORD_WIDTH-1:0]    mem_wdata_q;
  logic [WORD_WIDTH-1:0]    resp_data_q;
  logic [COUNTER_WIDTH-1:0] hit_q, miss_q;

  logic [TAG-1:0]        req_tag, inv_tag;
  logic [IDX-1:0]        req_idx, inv_idx;
  logic [OFF-1:0]        req_off;
  logic                  lookup_hit, inv_line_hit, inv_same_block, fill;
  logic [WORD_WIDTH-1:0] fill_words [WORDS_PER_BLOCK];

  assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG];
  assign req_idx = req_addr_q[OFF +: IDX];
  assign req_off = req_addr_q[OFF-1:0];
  assign inv_tag = inv_addr[ADDR_WIDTH-1 -: TAG];
  assign inv_idx = inv_addr[OFF +: IDX];

  assign lookup_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign inv_line_hit   = inv_valid && valid_q[inv_idx] && (tag_mem[inv_idx] == inv_tag);
  // Block-address match against the in-flight request, used to poison a pending fill.
  assign inv_same_block = inv_valid && ((inv_addr >> OFF) == (req_addr_q >> OFF));
  assign fill           = (state_q == S_MEM_WAIT) && mem_resp_valid;

  always_comb begin
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      fill_words[k] = mem_resp_data[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (cpu_req_valid) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = (!req_write_q && lookup_hit) ? S_RESPOND : S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready) state_d = req_write_q ? S_RESPOND : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) state_d = S_RESPOND;
      S_RESPOND:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign cpu_req_ready  = (state_q == S_IDLE);
  assign cpu_resp_valid = (state_q == S_RESPOND);
  assign cpu_resp_data  = resp_data_q;
  assign mem_req_valid  = (state_q == S_MEM_REQ);
  assign mem_req_write  = mem_write_q;
  assign mem_req_addr   = mem_addr_q;
  assign mem_req_wdata  = mem_wdata_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      valid_q     <= '0;
      inv_pend_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_req_valid) begin
        req_write_q <= cpu_req_write;
        req_addr_q  <= cpu_req_addr;
        req_wdata_q <= cpu_req_wdata;
      end
      if (state_q == S_LOOKUP) begin
        mem_write_q <= req_write_q;
        mem_addr_q  <= req_write_q ? req_addr_q : {req_addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        mem_wdata_q <= req_wdata_q;
        if (!req_write_q && lookup_hit) resp_data_q <= data_mem[req_idx][req_off];
        if (lookup_hit) begin
          if (hit_q != '1) hit_q <= hit_q + 1'b1;
        end else if (miss_q != '1) begin
          miss_q <= miss_q + 1'b1;
        end
      end
      if (state_q == S_MEM_REQ && mem_req_ready && req_write_q) resp_data_q <= req_wdata_q;
      if (fill) resp_data_q <= fill_words[req_off];
      if ((state_q == S_MEM_REQ || state_q == S_MEM_WAIT) && inv_same_block) inv_pend_q <= 1'b1;
      if (state_q == S_RESPOND) inv_pend_q <= 1'b0;
      // Invalidate clears first; a fill to a different block may then set the bit again.
      if (inv_line_hit) valid_q[inv_idx] <= 1'b0;
      if (fill) valid_q[req_idx] <= !(inv_pend_q || inv_same_block);
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == S_LOOKUP && req_write_q && lookup_hit) begin
      data_mem[req_idx][req_off] <= req_wdata_q;
    end
    if (fill) begin
      tag_mem[req_idx] <= req_tag;
      for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
        data_mem[req_idx][k] <= fill_words[k];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_direct_mapped_param.sv
`default_nettype none
// Bench for cache_direct_mapped_param: a table of CPU accesses plus hand-written
// invalidate, counter-saturation and mid-transaction reset sequences.
module tb_cache_direct_mapped_param;
  localparam int AW = 16;
  localparam int WW = 8;
  localparam int WPB = 2;
  localparam int NB = 128;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_write = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [WW-1:0] cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic [WW-1:0] cpu_resp_data;
  logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [WW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [WW*WPB-1:0] mem_resp_data = '0;
  logic          inv_valid = 1'b0;
  logic [AW-1:0] inv_addr = '0;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clock = ~clock;

  cache_direct_mapped_param #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_BLOCK(WPB),
    .NUM_BLOCKS(NB), .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data(cpu_resp_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int tests = 0;
  int fails = 0;
  int resp_seen = 0;
  logic [WW-1:0] exp_q[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [WW-1:0] wd;
    logic          exp_mem;
    logic [AW-1:0] maddr;
    logic [WW*WPB-1:0] fill;
    int            stall;
    logic [WW-1:0] data;
    int            hits;
    int            misses;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse pops the oldest expected data word.
  always @(negedge clock) begin
    if (cpu_resp_valid === 1'b1) begin
      resp_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got data 0x%0h, expected no response", cpu_resp_data);
      end else begin
        logic [WW-1:0] e;
        e = exp_q.pop_front();
        if (cpu_resp_data !== e) begin
          fails++;
          $display("FAIL resp_data: got 0x%0h, expected 0x%0h", cpu_resp_data, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_inv(input logic [AW-1:0] a);
    inv_valid = 1'b1;
    inv_addr  = a;
    step();
    inv_valid = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                        input logic exp_mem, input logic [AW-1:0] maddr,
                        input logic [WW*WPB-1:0] fill, input int stall, input logic inv_wait,
                        input logic [WW-1:0] data);
    int  target;
    logic got;
    chk("req_ready_idle", 32'(cpu_req_ready), 1);
    target = resp_seen + 1;
    exp_q.push_back(data);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    step();
    cpu_req_valid = 1'b0;
    cpu_req_wdata = 8'hxx;
    chk("req_ready_busy", 32'(cpu_req_ready), 0);
    if (!exp_mem) begin
      step();
      chk("hit_latency", 32'(cpu_resp_valid), 1);
      chk("hit_no_mem_req", 32'(mem_req_valid), 0);
    end else begin
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        step();
        got = mem_req_valid;
      end
      chk("mem_req_seen", 32'(got), 1);
      if (got) begin
        chk("mem_req_write", 32'(mem_req_write), 32'(wr));
        chk("mem_req_addr", 32'(mem_req_addr), 32'(maddr));
        if (wr) chk("mem_req_wdata", 32'(mem_req_wdata), 32'(wd));
        for (int s = 0; s < stall; s++) begin
          step();
          chk("mem_hold_valid", 32'(mem_req_valid), 1);
          chk("mem_hold_addr", 32'(mem_req_addr), 32'(maddr));
          if (wr) chk("mem_hold_wdata", 32'(mem_req_wdata), 32'(wd));
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        if (!wr) begin
          if (inv_wait) pulse_inv(addr);
          mem_resp_valid = 1'b1;
          mem_resp_data  = fill;
          step();
          mem_resp_valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < 5 && resp_seen < target; i++) step();
    chk("resp_count", 32'(resp_seen), 32'(target));
    step();
    chk("resp_one_pulse", 32'(cpu_resp_valid), 0);
  endtask

  initial begin
    int eh, em;
    //           wr    addr      wd     mem   maddr     fill      st  data   hit miss
    vecs[0] = '{1'b0, 16'h0102, 8'h00, 1'b1, 16'h0102, 16'hBEEF, 0, 8'hEF, 0, 1};
    vecs[1] = '{1'b0, 16'h0103, 8'h00, 1'b0, 16'h0000, 16'h0000, 0, 8'hBE, 1, 1};
    vecs[2] = '{1'b1, 16'h0102, 8'h55, 1'b1, 16'h0102, 16'h0000, 3, 8'h55, 2, 1};
    vecs[3] = '{1'b0, 16'h0102, 8'h00, 1'b0, 16'h0000, 16'h0000, 0, 8'h55, 3, 1};
    vecs[4] = '{1'b1, 16'h0400, 8'h77, 1'b1, 16'h0400, 16'h0000, 0, 8'h77, 3, 2};
    vecs[5] = '{1'b0, 16'h0400, 8'h00, 1'b1, 16'h0400, 16'h1234, 1, 8'h34, 3, 3};
    vecs[6] = '{1'b0, 16'h0401, 8'h00, 1'b0, 16'h0000, 16'h0000, 0, 8'h12, 4, 3};

    step();
    chk("rst_ready", 32'(cpu_req_ready), 1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 0);
    chk("rst_mem_valid", 32'(mem_req_valid), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_misses", 32'(miss_count), 0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_mem, vecs[i].maddr,
             vecs[i].fill, vecs[i].stall, 1'b0, vecs[i].data);
      chk("vec_hits", 32'(hit_count), 32'(vecs[i].hits));
      chk("vec_misses", 32'(miss_count), 32'(vecs[i].misses));
    end

    // Other tag at the same index leaves the line valid.
    pulse_inv(16'h0202);
    do_req(1'b0, 16'h0102, 8'h00, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 8'h55);
    chk("inv_other_hits", 32'(hit_count), 5);

    pulse_inv(16'h0102);
    do_req(1'b0, 16'h0102, 8'h00, 1'b1, 16'h0102, 16'hA1B2, 0, 1'b0, 8'hB2);
    chk("inv_match_misses", 32'(miss_count), 4);

    // Invalidate during the fill wait: data still returned, line installed invalid.
    pulse_inv(16'h0102);
    do_req(1'b0, 16'h0102, 8'h00, 1'b1, 16'h0102, 16'hC3D4, 0, 1'b1, 8'hD4);
    do_req(1'b0, 16'h0102, 8'h00, 1'b1, 16'h0102, 16'hE5F6, 0, 1'b0, 8'hF6);
    chk("pend_inv_misses", 32'(miss_count), 6);

    eh = 5;
    for (int i = 0; i < 12; i++) begin
      do_req(1'b0, 16'h0103, 8'h00, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 8'hE5);
      eh = (eh < 15) ? eh + 1 : 15;
      chk("sat_hits", 32'(hit_count), 32'(eh));
    end
    em = 6;
    for (int i = 0; i < 10; i++) begin
      do_req(1'b1, 16'h0800, 8'(i), 1'b1, 16'h0800, 16'h0000, 0, 1'b0, 8'(i));
      em = (em < 15) ? em + 1 : 15;
      chk("sat_misses", 32'(miss_count), 32'(em));
    end
    chk("sat_hits_hold", 32'(hit_count), 15);

    // Reset while waiting for a fill.
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 16'h0600;
    step();
    cpu_req_valid = 1'b0;
    step();
    chk("rw_mem_valid", 32'(mem_req_valid), 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_ready", 32'(cpu_req_ready), 1);
    chk("rw_resp_valid", 32'(cpu_resp_valid), 0);
    chk("rw_resp_data", 32'(cpu_resp_data), 0);
    chk("rw_mem_valid0", 32'(mem_req_valid), 0);
    chk("rw_mem_addr", 32'(mem_req_addr), 0);
    chk("rw_hits", 32'(hit_count), 0);
    chk("rw_misses", 32'(miss_count), 0);
    step();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 16'h9999;
    step();
    mem_resp_valid = 1'b0;
    step();
    chk("late_fill_no_resp", 32'(cpu_resp_valid), 0);
    chk("late_fill_idle", 32'(cpu_req_ready), 1);
    chk("late_fill_no_mem", 32'(mem_req_valid), 0);
    do_req(1'b0, 16'h0103, 8'h00, 1'b1, 16'h0102, 16'h5566, 0, 1'b0, 8'h55);
    chk("post_rst_hits", 32'(hit_count), 0);
    chk("post_rst_misses", 32'(miss_count), 1);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
